// File: rtl/mmio_button_in.sv
// mmio_button_in: synchronised, debounced push-button inputs exposed as a memory-mapped register window
// Holds sticky press flags, a 16-bit press counter and a level interrupt; reads return one cycle after the address.
module mmio_button_in #(
  parameter int          NBTN         = 2,
  parameter int          DEBOUNCE     = 4,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0010
) (
  input  logic            clk,
  input  logic            sys_rst_n,
  input  logic [NBTN-1:0] btn_n,
  input  logic [31:0]     bus_address,
  input  logic            bus_write,
  input  logic [31:0]     bus_write_data,
  output logic [31:0]     read_data,
  output logic            hit,
  output logic            irq
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [NBTN-1:0] sync1_q, sync2_q, pressed, level_q, level_d, rise;
  logic [NBTN-1:0] events_q, events_d, irq_en_q, irq_en_d, clr;
  logic [CW-1:0]   cnt_q [NBTN];
  logic [CW-1:0]   cnt_d [NBTN];
  logic [15:0]     count_q, count_d, pc;
  logic [31:0]     read_data_q, read_data_d;
  logic            hit_q, irq_q, irq_d, sel, wr;
  logic [1:0]      off;
  assign pressed = ~sync2_q;
  // a level flips only after DEBOUNCE consecutive disagreeing samples
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NBTN; i++) begin
      if (pressed[i] == level_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
        level_d[i] = pressed[i];
        cnt_d[i]   = '0;
      end else cnt_d[i] = cnt_q[i] + CW'(1);
    end
  end
  assign rise = level_d & ~level_q;
  always_comb begin
    pc = '0;
    for (int i = 0; i < NBTN; i++) pc = pc + 16'(rise[i]);
  end
  assign sel = bus_address[31:4] == BASE_ADDRESS[31:4];
  assign off = bus_address[3:2];
  assign wr  = sel && bus_write;
  assign clr = (wr && off == 2'd1) ? bus_write_data[NBTN-1:0] : '0;
  // a rise in the same cycle as a W1C keeps the flag set
  assign events_d = (events_q & ~clr) | rise;
  assign irq_en_d = (wr && off == 2'd3) ? bus_write_data[NBTN-1:0] : irq_en_q;
  assign count_d  = count_q + pc;
  assign irq_d    = |(events_d & irq_en_d);
  assign read_data_d = !sel        ? '0 :
                       off == 2'd0 ? 32'(level_q) :
                       off == 2'd1 ? 32'(events_q) :
                       off == 2'd2 ? {16'h0, count_q} : 32'(irq_en_q);
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      level_q     <= '0;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
      events_q    <= '0;
      irq_en_q    <= '0;
      count_q     <= '0;
      read_data_q <= '0;
      hit_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= btn_n;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      events_q    <= events_d;
      irq_en_q    <= irq_en_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
      hit_q       <= sel;
      irq_q       <= irq_d;
    end
  end
  assign read_data = read_data_q;
  assign hit       = hit_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_mmio_button_in.sv
// tb_mmio_button_in: directed test-plan scenarios plus random traffic, checked against a window-based behavioural model
module tb_mmio_button_in;
  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  btn_n;
  logic [31:0] bus_address, bus_write_data, read_data;
  logic        bus_write, hit, irq;
  int          n_checks = 0, n_errors = 0;
  logic [1:0]  btn_cur = 2'b11;
  logic [1:0]  m_s1, m_s2, m_lvl, m_ev, m_en;
  logic [3:0]  m_hist [2];
  logic [15:0] m_cnt;
  logic [31:0] m_rd, v;
  logic        m_hit, m_irq;
  mmio_button_in #(.NBTN(2), .DEBOUNCE(4), .BASE_ADDRESS(32'h10)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .btn_n(btn_n), .bus_address(bus_address),
    .bus_write(bus_write), .bus_write_data(bus_write_data), .read_data(read_data),
    .hit(hit), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_s1 = 2'b11; m_s2 = 2'b11; m_lvl = '0; m_ev = '0; m_en = '0; m_cnt = '0;
    m_hist[0] = '0; m_hist[1] = '0; m_rd = '0; m_hit = 1'b0; m_irq = 1'b0;
  endtask
  // level flips when the last four synchronised samples all disagree with it
  task automatic model_step(input logic [1:0] b, input logic [31:0] a, input logic w, input logic [31:0] d);
    logic [1:0] pr, nl, rise;
    logic [31:0] rv;
    logic s;
    pr = ~m_s2;
    for (int i = 0; i < 2; i++) begin
      m_hist[i] = {m_hist[i][2:0], pr[i]};
      nl[i] = (m_hist[i] == {4{~m_lvl[i]}}) ? ~m_lvl[i] : m_lvl[i];
    end
    rise = nl & ~m_lvl;
    s = a[31:4] == 28'h1;
    case (a[3:2])
      2'd0: rv = {30'h0, m_lvl};
      2'd1: rv = {30'h0, m_ev};
      2'd2: rv = {16'h0, m_cnt};
      default: rv = {30'h0, m_en};
    endcase
    m_rd = s ? rv : 32'h0;
    m_hit = s;
    if (s && w && a[3:2] == 2'd1) m_ev = m_ev & ~d[1:0];
    if (s && w && a[3:2] == 2'd3) m_en = d[1:0];
    m_ev = m_ev | rise;
    m_cnt = m_cnt + 16'($countones(rise));
    m_irq = |(m_ev & m_en);
    m_lvl = nl;
    m_s2 = m_s1;
    m_s1 = b;
  endtask
  task automatic step(input logic [1:0] b, input logic [31:0] a, input logic w, input logic [31:0] d);
    btn_n = b; bus_address = a; bus_write = w; bus_write_data = d;
    @(posedge clk);
    if (!sys_rst_n) model_reset();
    else model_step(b, a, w, d);
    @(negedge clk);
    check("read_data", read_data, m_rd);
    check("hit", {31'h0, hit}, {31'h0, m_hit});
    check("irq", {31'h0, irq}, {31'h0, m_irq});
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    step(btn_cur, a, 1'b0, 32'h0);
    r = read_data;
  endtask
  task automatic wrt(input logic [31:0] a, input logic [31:0] d);
    step(btn_cur, a, 1'b1, d);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(btn_cur, 32'h0, 1'b0, 32'h0);
  endtask
  initial begin
    sys_rst_n = 1'b0;
    model_reset();
    idle(2);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd(32'h10 + 32'(4 * k), v);
      check("rst_reg", v, 32'h0);
      check("rst_hit", {31'h0, hit}, 32'h1);
    end
    rd(32'h20, v);
    check("miss_hit", {31'h0, hit}, 32'h0);
    btn_cur = 2'b10;
    for (int j = 1; j <= 7; j++) begin
      rd(32'h10, v);
      if (j == 6) check("lvl_before", v, 32'h0);
      if (j == 7) check("lvl_after", v, 32'h1);
    end
    rd(32'h14, v); check("ev_press", v, 32'h1);
    rd(32'h18, v); check("cnt_press", v, 32'h1);
    btn_cur = 2'b11; idle(8);
    rd(32'h10, v); check("lvl_rel", v, 32'h0);
    rd(32'h14, v); check("ev_rel", v, 32'h1);
    rd(32'h18, v); check("cnt_rel", v, 32'h1);
    btn_cur = 2'b01; idle(3);
    btn_cur = 2'b11; idle(8);
    rd(32'h10, v); check("lvl_glitch", v, 32'h0);
    rd(32'h14, v); check("ev_glitch", v, 32'h1);
    rd(32'h18, v); check("cnt_glitch", v, 32'h1);
    wrt(32'h14, 32'h3);
    wrt(32'h1C, 32'h3);
    check("irq_idle", {31'h0, irq}, 32'h0);
    btn_cur = 2'b01;
    for (int j = 1; j <= 6; j++) begin
      idle(1);
      if (j == 5) check("irq_before", {31'h0, irq}, 32'h0);
      if (j == 6) check("irq_set", {31'h0, irq}, 32'h1);
    end
    rd(32'h14, v); check("ev_btn1", v, 32'h2);
    wrt(32'h14, 32'h2);
    check("irq_clr", {31'h0, irq}, 32'h0);
    rd(32'h14, v); check("ev_clr", v, 32'h0);
    wrt(32'h10, 32'hFF);
    wrt(32'h18, 32'hFF);
    rd(32'h10, v); check("lvl_ro", v, 32'h2);
    rd(32'h18, v); check("cnt_ro", v, 32'h2);
    rd(32'h1C, v); check("irq_en", v, 32'h3);
    btn_cur = 2'b11; idle(8);
    wrt(32'h1C, 32'h0);
    btn_cur = 2'b10; idle(5);
    wrt(32'h14, 32'h1);
    rd(32'h14, v); check("set_wins", v, 32'h1);
    btn_cur = 2'b11; idle(8);
    force dut.count_q = 16'hFFFF;
    #1 release dut.count_q;
    m_cnt = 16'hFFFF;
    rd(32'h18, v); check("cnt_preload", v, 32'hFFFF);
    btn_cur = 2'b00; idle(6);
    rd(32'h18, v); check("cnt_wrap", v, 32'h1);
    btn_cur = 2'b11; idle(8);
    btn_cur = 2'b10; idle(2);
    sys_rst_n = 1'b0;
    idle(1);
    rd(32'h18, v); check("cnt_in_rst", v, 32'h0);
    sys_rst_n = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      rd(32'h10, v);
      if (j == 6) check("rst_lvl_before", v, 32'h0);
      if (j == 7) check("rst_lvl_after", v, 32'h1);
    end
    rd(32'h14, v); check("rst_ev", v, 32'h1);
    rd(32'h18, v); check("rst_cnt", v, 32'h1);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 5) == 0) btn_cur = 2'($urandom);
      a = ($urandom_range(0, 3) != 0) ? 32'h10 + 32'($urandom_range(0, 15)) : $urandom;
      sys_rst_n = ($urandom_range(0, 199) != 0);
      step(btn_cur, a, $urandom_range(0, 3) == 0, $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
